ram: RTL and testbench



---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_if.sv | 26 ++
 rtl/ram_storage.sv | 45 ++++
 rtl/ram.sv | 39 +++
 tb/tb_ram.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared types, default widths and helpers for the ram component.
package ram_pkg;

    localparam int unsigned RAM_DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned RAM_DEFAULT_ADDR_WIDTH = 8;

    typedef logic [RAM_DEFAULT_DATA_WIDTH-1:0] word_t;

    // Number of words addressable by an address of the given width.
    function automatic int unsigned depth(input int unsigned addr_width);
        return 32'(1) << addr_width;
    endfunction

endpackage : ram_pkg

// File: rtl/ram_if.sv
// Address/data bus of the single-port ram; the user side is the master.
interface ram_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
);

    logic [ADDR_WIDTH-1:0] Addr;
    logic                  Write;
    logic [DATA_WIDTH-1:0] Input;
    logic [DATA_WIDTH-1:0] Output;

    modport master (
        output Addr,
        output Write,
        output Input,
        input  Output
    );

    modport slave (
        input  Addr,
        input  Write,
        input  Input,
        output Output
    );

endinterface : ram_if

// File: rtl/ram_storage.sv
// Word array and write port of the ram.
// RAM_RESET_CLEAR_EN: when defined, reset asynchronously clears every word;
// otherwise the array has no reset so it can map onto block RAM.
module ram_storage
    import ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RAM_DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RAM_DEFAULT_ADDR_WIDTH,
    localparam int unsigned DEPTH     = depth(ADDR_WIDTH)
) (
    input  logic                  clk_i,
`ifdef RAM_RESET_CLEAR_EN
    input  logic                  rst_n_i,
`endif
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] mem_o [DEPTH]
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

`ifdef RAM_RESET_CLEAR_EN
    // Write port with asynchronous clear of the whole array.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end
`else
    // Write port; contents are retained across reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end
`endif

    assign mem_o = mem_q;

endmodule : ram_storage

// File: rtl/ram.sv
// Single-port RAM: synchronous write, asynchronous (combinational) read.
// RAM_RESET_CLEAR_EN: when defined, reset clears the array to zero.
module ram
    import ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RAM_DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RAM_DEFAULT_ADDR_WIDTH
) (
    input  logic Clk,
    input  logic Rst_n,
    ram_if.slave bus
);

    localparam int unsigned DEPTH = depth(ADDR_WIDTH);

    logic                  wr_en_c;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Reset wins over a simultaneous write: a write seen while Rst_n is low is dropped.
    assign wr_en_c = bus.Write & Rst_n;

    ram_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_storage (
        .clk_i   (Clk),
`ifdef RAM_RESET_CLEAR_EN
        .rst_n_i (Rst_n),
`endif
        .we_i    (wr_en_c),
        .addr_i  (bus.Addr),
        .wdata_i (bus.Input),
        .mem_o   (mem)
    );

    // Read mux: always active, shows the stored word until the write edge (read-first).
    assign bus.Output = mem[bus.Addr];

endmodule : ram

// File: tb/tb_ram.sv
// Directed self-checking bench for ram (default 8-bit data, 8-bit address).
module tb_ram;
    import ram_pkg::*;

    logic Clk;
    logic Rst_n;
    int   n_checks;
    int   n_fail;

    ram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

    ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input word_t exp);
        n_checks++;
        assert (bus.Output === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, bus.Output, exp);
        end
    endtask

    // Read address a combinationally, without a clock edge.
    task automatic read_chk(input string tag, input logic [7:0] a, input word_t exp);
        bus.Addr = a;
        #1;
        check(tag, exp);
    endtask

    // Single write on the next rising edge, then deassert Write.
    task automatic write_word(input logic [7:0] a, input word_t d);
        @(negedge Clk);
        bus.Addr  = a;
        bus.Input = d;
        bus.Write = 1'b1;
        @(negedge Clk);
        bus.Write = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        bus.Addr  = '0;
        bus.Input = '0;
        bus.Write = 1'b0;
        Rst_n     = 1'b1;
        #2 Rst_n  = 1'b0;

        // Reset phase
        repeat (3) @(negedge Clk);
`ifdef RAM_RESET_CLEAR_EN
        read_chk("rst_during_a0", 8'd0, 8'h00);
`endif
        Rst_n = 1'b1;
        @(negedge Clk);
`ifdef RAM_RESET_CLEAR_EN
        read_chk("rst_a0",   8'd0,   8'h00);
        read_chk("rst_a1",   8'd1,   8'h00);
        read_chk("rst_a255", 8'd255, 8'h00);
`endif

        // Single write / read back
        write_word(8'd0, 8'd42);
        read_chk("single_a0", 8'd0, 8'd42);

        // Sequential fill on consecutive edges
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            bus.Addr  = 8'(i);
            bus.Input = 8'(i);
            bus.Write = 1'b1;
        end
        @(negedge Clk);
        bus.Write = 1'b0;
        for (int i = 0; i < 100; i++) begin
            read_chk($sformatf("fill_a%0d", i), 8'(i), 8'(i));
        end

        // Write-disable and address boundaries
        write_word(8'd255, 8'hFF);
        write_word(8'd0,   8'h00);
        bus.Addr  = 8'd255;
        bus.Input = 8'h55;
        bus.Write = 1'b0;
        repeat (4) @(negedge Clk);
        read_chk("wdis_a255", 8'd255, 8'hFF);
        read_chk("wdis_a0",   8'd0,   8'h00);
        read_chk("wdis_a99",  8'd99,  8'd99);

        // Read-during-write: old word before the edge, new word after
        write_word(8'd7, 8'h11);
        read_chk("rdw_setup", 8'd7, 8'h11);
        bus.Input = 8'h22;
        bus.Write = 1'b1;
        #1;
        check("rdw_before_edge", 8'h11);
        @(posedge Clk);
        #1;
        check("rdw_after_edge", 8'h22);
        @(negedge Clk);
        bus.Write = 1'b0;

        // Reset spanning a write edge drops the write
        write_word(8'd5, 8'h44);
        read_chk("rstw_setup", 8'd5, 8'h44);
        @(negedge Clk);
        bus.Addr  = 8'd5;
        bus.Input = 8'h33;
        bus.Write = 1'b1;
        Rst_n     = 1'b0;
        #1;
`ifdef RAM_RESET_CLEAR_EN
        check("rstw_during", 8'h00);
`else
        check("rstw_during", 8'h44);
`endif
        @(posedge Clk);
        @(negedge Clk);
        bus.Write = 1'b0;
        Rst_n     = 1'b1;
`ifdef RAM_RESET_CLEAR_EN
        read_chk("rstw_a5", 8'd5, 8'h00);
        read_chk("rstw_a7", 8'd7, 8'h00);
`else
        read_chk("rstw_a5", 8'd5, 8'h44);
        read_chk("rstw_a7", 8'd7, 8'h22);
`endif

        // First write right after reset release lands
        write_word(8'd5, 8'hA5);
        read_chk("post_rst_a5", 8'd5, 8'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ram
